// File: rtl/md_pkg.sv
// Shared constants for the motion-update engine: particle layout,
// per-axis migration direction codes and FSM state encoding.
package md_pkg;

    localparam int PARTICLE_W = 97;
    localparam int COORD_W    = 32;
    localparam int VALID_BIT  = 96;

    localparam logic [1:0] DIR_STAY = 2'b00;
    localparam logic [1:0] DIR_POS  = 2'b01;
    localparam logic [1:0] DIR_NEG  = 2'b11;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_LATCH  = 3'd2;
    localparam logic [2:0] ST_UPDATE = 3'd3;
    localparam logic [2:0] ST_EMIT   = 3'd4;
    localparam logic [2:0] ST_TERM   = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;

endpackage

// File: rtl/motion_update_node_axis.sv
// Single-axis integrator: advances one coordinate by v*dt, rebases it into
// the neighbouring cell when it leaves [0, 2^CELL_BITS), and flags steps
// that are too large to be a single-cell hop.
module axis_integrator
    import md_pkg::*;
#(
    parameter int CELL_BITS = 16,
    parameter int DT_SHIFT  = 4
) (
    input  logic signed [COORD_W-1:0] i_p,
    input  logic signed [COORD_W-1:0] i_v,
    output logic signed [COORD_W-1:0] o_np,
    output logic        [1:0]         o_dir,
    output logic                      o_overflow
);

    localparam logic signed [COORD_W-1:0] CELL_SPAN = 32'sd1 <<< CELL_BITS;

    logic signed [COORD_W-1:0] w_dp;
    logic signed [COORD_W-1:0] w_sum;

    assign w_dp       = i_v >>> DT_SHIFT;
    assign w_sum      = i_p + w_dp;
    assign o_overflow = (w_dp >= CELL_SPAN) || (w_dp <= -CELL_SPAN);

    // Fold the raw sum back into cell-local range and report which way it left
    always_comb begin
        o_np  = w_sum;
        o_dir = DIR_STAY;
        if (w_sum < 0) begin
            o_np  = w_sum + CELL_SPAN;
            o_dir = DIR_NEG;
        end else if (w_sum >= CELL_SPAN) begin
            o_np  = w_sum - CELL_SPAN;
            o_dir = DIR_POS;
        end
    end

endmodule

// File: rtl/motion_update_node.sv
// Per-cell position update engine. Walks the read half of the position
// cache, integrates each valid particle with its cached velocity, keeps
// in-cell particles in the write half and hands leavers to a neighbour.
module motion_update_node
    import md_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int CELL_BITS = 16,
    parameter int DT_SHIFT  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  CTL_READY,
    input  logic                  CTL_DOUBLE_BUFFER,
    output logic                  CTL_DONE,
    output logic [31:0]           p_raddr,
    output logic [31:0]           v_raddr,
    input  logic [PARTICLE_W-1:0] p_rdata,
    input  logic [PARTICLE_W-1:0] v_rdata,
    output logic [31:0]           p_waddr,
    output logic [PARTICLE_W-1:0] p_wdata,
    output logic                  p_wr_en,
    output logic                  mig_valid,
    input  logic                  mig_ready,
    output logic [PARTICLE_W-1:0] mig_data,
    output logic [5:0]            mig_dir,
    output logic [31:0]           wr_count,
    output logic                  err
);

    localparam int IDX_W = $clog2(DEPTH) + 1;

    logic [2:0]            r_state;
    logic                  r_db;
    logic [IDX_W-1:0]      r_idx;
    logic [31:0]           r_wrCount;
    logic                  r_err;
    logic [3*COORD_W-1:0]  r_pos;
    logic [3*COORD_W-1:0]  r_vel;
    logic [3*COORD_W-1:0]  r_np;
    logic [5:0]            r_dir;

    logic [31:0]           w_rbase;
    logic [31:0]           w_wbase;
    logic [3*COORD_W-1:0]  w_np;
    logic [5:0]            w_dir;
    logic [2:0]            w_ovf;
    logic                  w_isLocal;
    logic                  w_unusedVelValid;

    assign w_rbase          = r_db ? 32'(DEPTH) : 32'd0;
    assign w_wbase          = r_db ? 32'd0 : 32'(DEPTH);
    assign w_isLocal        = (r_dir == 6'b000000);
    assign w_unusedVelValid = v_rdata[VALID_BIT];

    for (genvar a = 0; a < 3; a++) begin : g_axis
        axis_integrator #(
            .CELL_BITS (CELL_BITS),
            .DT_SHIFT  (DT_SHIFT)
        ) u_axis (
            .i_p        (r_pos[COORD_W*a +: COORD_W]),
            .i_v        (r_vel[COORD_W*a +: COORD_W]),
            .o_np       (w_np[COORD_W*a +: COORD_W]),
            .o_dir      (w_dir[2*a +: 2]),
            .o_overflow (w_ovf[a])
        );
    end

    // Scan sequencer: fetch, latch, integrate, emit per particle, then terminate
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_db      <= 1'b0;
            r_idx     <= '0;
            r_wrCount <= '0;
            r_err     <= 1'b0;
            r_pos     <= '0;
            r_vel     <= '0;
            r_np      <= '0;
            r_dir     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (CTL_READY) begin
                        r_state   <= ST_FETCH;
                        r_idx     <= '0;
                        r_wrCount <= '0;
                        r_db      <= CTL_DOUBLE_BUFFER;
                    end
                end
                ST_FETCH: r_state <= ST_LATCH;
                ST_LATCH: begin
                    r_pos   <= p_rdata[3*COORD_W-1:0];
                    r_vel   <= v_rdata[3*COORD_W-1:0];
                    r_state <= p_rdata[VALID_BIT] ? ST_UPDATE : ST_TERM;
                end
                ST_UPDATE: begin
                    r_np    <= w_np;
                    r_dir   <= w_dir;
                    r_state <= ST_EMIT;
                    if (|w_ovf) begin
                        r_err <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (w_isLocal || mig_ready) begin
                        if (w_isLocal) begin
                            r_wrCount <= r_wrCount + 32'd1;
                        end
                        r_idx   <= r_idx + IDX_W'(1);
                        r_state <= (r_idx == IDX_W'(DEPTH - 1)) ? ST_TERM : ST_FETCH;
                    end
                end
                ST_TERM: r_state <= ST_DONE;
                ST_DONE: begin
                    if (!CTL_READY) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Cache ports and migrant interface decoded from the current state
    always_comb begin
        p_raddr   = 32'd0;
        p_wr_en   = 1'b0;
        p_waddr   = 32'd0;
        p_wdata   = '0;
        mig_valid = 1'b0;
        mig_data  = '0;
        mig_dir   = 6'b000000;
        case (r_state)
            ST_FETCH: p_raddr = w_rbase + 32'(r_idx);
            ST_EMIT: begin
                if (w_isLocal) begin
                    p_wr_en = 1'b1;
                    p_waddr = w_wbase + r_wrCount;
                    p_wdata = {1'b1, r_np};
                end else begin
                    mig_valid = 1'b1;
                    mig_data  = {1'b1, r_np};
                    mig_dir   = r_dir;
                end
            end
            ST_TERM: begin
                if (r_wrCount < 32'(DEPTH)) begin
                    p_wr_en = 1'b1;
                    p_waddr = w_wbase + r_wrCount;
                end
            end
            default: ;
        endcase
    end

    assign v_raddr  = p_raddr;
    assign CTL_DONE = (r_state == ST_DONE);
    assign wr_count = r_wrCount;
    assign err      = r_err;

endmodule
